axis_uart_tx: RTL and testbench

- AXI-stream sink that serializes each accepted word onto an asynchronous serial line (UART 8N1 style by default).
- Sits at the consumer end of the stream FIFOs: its idata/ivalid/iready connect directly to a FIFO's odata/ovalid/oready.
- Single clock domain. Bit timing comes from an integer clock divider.

---
 rtl/axis_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_axis_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_tx.sv
// AXI-stream sink that serializes each accepted word onto a UART-style line:
// one start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
module axis_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLOCK_DIV  = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  ivalid,
    output logic                  iready,
    output logic                  txd,
    output logic                  busy
);

    localparam int BW = $clog2(CLOCK_DIV);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCK_DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLOCK_DIV - 2);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                state_r;
    logic [BW-1:0]         baud_cnt_r;
    logic [CW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;

    logic baud_end_s;
    logic accept_s;
    logic last_stop_s;

    // Bit-period boundary, handshake and final-stop-bit decodes
    always_comb begin
        baud_end_s  = 1'b0;
        accept_s    = 1'b0;
        last_stop_s = 1'b0;
        if (baud_cnt_r == BAUD_LAST) begin
            baud_end_s = 1'b1;
        end else begin
            baud_end_s = 1'b0;
        end
        if (ivalid && iready) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == S_STOP) && (bit_cnt_r == STOP_LAST)) begin
            last_stop_s = 1'b1;
        end else begin
            last_stop_s = 1'b0;
        end
    end

    // Frame sequencer; all outputs are driven straight from flops
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            iready     <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                    if (accept_s) begin
                        shift_r <= idata;
                        iready  <= 1'b0;
                        busy    <= 1'b1;
                        txd     <= 1'b0;
                        state_r <= S_START;
                    end else begin
                        iready  <= 1'b1;
                        busy    <= 1'b0;
                        txd     <= 1'b1;
                    end
                end

                S_START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                        txd        <= shift_r[0];
                        shift_r    <= shift_r >> 1'b1;
                        state_r    <= S_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= '0;
                            txd       <= 1'b1;
                            state_r   <= S_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                            txd       <= shift_r[0];
                            shift_r   <= shift_r >> 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end

                S_STOP: begin
                    // Open the input one cycle early so a waiting word follows with no gap
                    if (last_stop_s && (baud_cnt_r == BAUD_PRE)) begin
                        iready <= 1'b1;
                    end else begin
                        iready <= iready;
                    end
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        if (last_stop_s) begin
                            bit_cnt_r <= '0;
                            if (accept_s) begin
                                shift_r <= idata;
                                iready  <= 1'b0;
                                busy    <= 1'b1;
                                txd     <= 1'b0;
                                state_r <= S_START;
                            end else begin
                                busy    <= 1'b0;
                                txd     <= 1'b1;
                                state_r <= S_IDLE;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end

                default: begin
                    state_r    <= S_IDLE;
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                    iready     <= 1'b0;
                    txd        <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: a cycle-level line model plus a serial decoder
// fed by an expected-byte scoreboard; two parameter sets are exercised.
module tb_axis_uart_tx;

    localparam int CDA = 4;
    localparam int NA  = 10;
    localparam int CDB = 3;
    localparam int NB  = 11;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] a_idata, b_idata;
    logic       a_ivalid, b_ivalid;
    logic       a_iready, a_txd, a_busy;
    logic       b_iready, b_txd, b_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model state: last accepted word and its handshake cycle
    longint     a_t = 0, b_t = 0;
    logic [7:0] a_d = 8'h00, b_d = 8'h00;
    bit         a_hf = 1'b0, b_hf = 1'b0;
    bit         a_ok = 1'b0, b_ok = 1'b0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    logic [7:0] fifo_q[$];

    bit         dec_active = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;
    int         n_decoded = 0;
    int         a_busy_cnt = 0, a_nrdy_cnt = 0, b_busy_cnt = 0;

    axis_uart_tx #(.DATA_WIDTH(8), .CLOCK_DIV(CDA), .STOP_BITS(1)) dut_a (
        .clock(clock), .resetn(resetn), .idata(a_idata), .ivalid(a_ivalid),
        .iready(a_iready), .txd(a_txd), .busy(a_busy)
    );

    axis_uart_tx #(.DATA_WIDTH(8), .CLOCK_DIV(CDB), .STOP_BITS(2)) dut_b (
        .clock(clock), .resetn(resetn), .idata(b_idata), .ivalid(b_ivalid),
        .iready(b_iready), .txd(b_txd), .busy(b_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit in_frame(int c, longint t, bit hf, int cd, int n);
        return hf && (c >= t) && (c < t + n * cd);
    endfunction

    function automatic logic exp_txd(int c, longint t, logic [7:0] d, bit hf, int cd, int n);
        int slot;
        logic [7:0] dv;
        if (!in_frame(c, t, hf, cd, n)) return 1'b1;
        slot = (c - int'(t)) / cd;
        dv = d;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return dv[slot-1];
        return 1'b1;
    endfunction

    function automatic logic exp_rdy(int c, longint t, bit hf, bit ok, int cd, int n);
        if (!ok) return 1'b0;
        return !(hf && (c >= t) && (c < t + n * cd - 1));
    endfunction

    // Model update at each edge: record handshakes, push accepted words
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!resetn) begin
            a_hf <= 1'b0; a_ok <= 1'b0;
            b_hf <= 1'b0; b_ok <= 1'b0;
            exp_q.delete();
        end else begin
            a_ok <= 1'b1;
            b_ok <= 1'b1;
            if (a_ivalid && a_iready) begin
                a_t  <= longint'(cyc + 1);
                a_d  <= a_idata;
                a_hf <= 1'b1;
                exp_q.push_back(a_idata);
            end
            if (b_ivalid && b_iready) begin
                b_t  <= longint'(cyc + 1);
                b_d  <= b_idata;
                b_hf <= 1'b1;
            end
        end
    end

    // Cycle-level output comparison against the model, sampled mid-cycle
    always @(negedge clock) begin
        if (!resetn) begin
            chk("a_txd_rst", a_txd, 1); chk("a_busy_rst", a_busy, 0); chk("a_rdy_rst", a_iready, 0);
            chk("b_txd_rst", b_txd, 1); chk("b_busy_rst", b_busy, 0); chk("b_rdy_rst", b_iready, 0);
        end else begin
            chk("a_txd", a_txd, exp_txd(cyc, a_t, a_d, a_hf, CDA, NA));
            chk("a_busy", a_busy, in_frame(cyc, a_t, a_hf, CDA, NA));
            chk("a_iready", a_iready, exp_rdy(cyc, a_t, a_hf, a_ok, CDA, NA));
            chk("b_txd", b_txd, exp_txd(cyc, b_t, b_d, b_hf, CDB, NB));
            chk("b_busy", b_busy, in_frame(cyc, b_t, b_hf, CDB, NB));
            chk("b_iready", b_iready, exp_rdy(cyc, b_t, b_hf, b_ok, CDB, NB));
            if (a_busy) a_busy_cnt <= a_busy_cnt + 1;
            if (!a_iready) a_nrdy_cnt <= a_nrdy_cnt + 1;
            if (b_busy) b_busy_cnt <= b_busy_cnt + 1;
        end
    end

    // Serial decoder on line A; pops the scoreboard at each stop bit
    always @(negedge clock) begin
        logic [7:0] eb;
        if (!resetn) begin
            dec_active <= 1'b0;
        end else if (!dec_active) begin
            if (a_txd === 1'b0) begin
                dec_active <= 1'b1;
                dec_cnt    <= 1;
                start_q.push_back(cyc);
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (dec_cnt == CDA * (1 + k) + CDA / 2) dec_byte[k] <= a_txd;
            end
            if (dec_cnt == CDA * 9 + CDA / 2) begin
                chk("stop_level", a_txd, 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got %0h expected none", dec_byte);
                end else begin
                    eb = exp_q.pop_front();
                    chk("rx_byte", dec_byte, eb);
                    n_decoded <= n_decoded + 1;
                end
            end
            if (dec_cnt == CDA * NA - 1) dec_active <= 1'b0;
            dec_cnt <= dec_cnt + 1;
        end
    end

    // Offer a word on A from a negedge; returns at the negedge after the handshake
    task automatic send_a(input logic [7:0] d, input bit hold);
        int k = 0;
        a_idata  = d;
        a_ivalid = 1'b1;
        while (a_iready !== 1'b1 && k < 1000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 1000) begin
            n_checks++; n_errors++;
            $display("FAIL a_handshake_timeout: got iready=%b expected 1", a_iready);
        end
        @(negedge clock);
        if (!hold) a_ivalid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int k = 0;
        b_idata  = d;
        b_ivalid = 1'b1;
        while (b_iready !== 1'b1 && k < 1000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 1000) begin
            n_checks++; n_errors++;
            $display("FAIL b_handshake_timeout: got iready=%b expected 1", b_iready);
        end
        @(negedge clock);
        b_ivalid = 1'b0;
    endtask

    initial begin
        int base_busy, base_nrdy, base_bbusy, s0, base_dec, k;
        resetn   = 1'b0;
        a_ivalid = 1'b0; a_idata = 8'h00;
        b_ivalid = 1'b0; b_idata = 8'h00;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (50) @(negedge clock);

        // single frame 0xA5
        base_busy = a_busy_cnt; base_nrdy = a_nrdy_cnt;
        send_a(8'hA5, 1'b0);
        repeat (45) @(negedge clock);
        chk("single_busy_len", a_busy_cnt - base_busy, 40);
        chk("single_nrdy_len", a_nrdy_cnt - base_nrdy, 39);

        // back-to-back 0x00 then 0xFF
        base_busy = a_busy_cnt; s0 = start_q.size();
        send_a(8'h00, 1'b1);
        send_a(8'hFF, 1'b0);
        repeat (85) @(negedge clock);
        chk("b2b_busy_len", a_busy_cnt - base_busy, 80);
        chk("b2b_starts", start_q.size() - s0, 2);
        if (start_q.size() - s0 == 2) chk("b2b_pitch", start_q[s0+1] - start_q[s0], 40);

        // two stop bits on B
        base_bbusy = b_busy_cnt;
        send_b(8'h81);
        repeat (40) @(negedge clock);
        chk("b_busy_len", b_busy_cnt - base_bbusy, 33);

        // reset during data bit 3 of 0x55
        send_a(8'h55, 1'b0);
        repeat (17) @(negedge clock);
        chk("pre_reset_txd", a_txd, 0);
        #2 resetn = 1'b0;
        #1;
        chk("async_txd", a_txd, 1);
        chk("async_busy", a_busy, 0);
        chk("async_iready", a_iready, 0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (5) @(negedge clock);
        base_dec = n_decoded;
        send_a(8'h3C, 1'b0);
        repeat (45) @(negedge clock);
        chk("post_reset_rx", n_decoded - base_dec, 1);

        // burst through a behavioural FIFO
        base_dec = n_decoded;
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
        while (fifo_q.size() > 0) begin
            logic [7:0] w;
            w = fifo_q.pop_front();
            send_a(w, fifo_q.size() > 0);
        end
        k = 0;
        while ((a_busy || dec_active) && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("fifo_drain_timeout", k < 200, 1);
        repeat (5) @(negedge clock);
        chk("fifo_rx_count", n_decoded - base_dec, 16);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
